// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer slice: CDB field layout, tag and
// register widths, and the ROB entry record.
package reorder_buffer_pkg;

    localparam int unsigned CDB_W       = 148;
    localparam int unsigned CDB_TAG_LO  = 0;
    localparam int unsigned CDB_TAG_HI  = 2;
    localparam int unsigned CDB_VALID   = 3;
    localparam int unsigned CDB_RES_LO  = 4;
    localparam int unsigned CDB_RES_HI  = 35;
    localparam int unsigned CDB_COND    = 36;
    localparam int unsigned CDB_NZCV_LO = 37;
    localparam int unsigned CDB_NZCV_HI = 40;

    localparam int unsigned TAG_W    = 3;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_W    = 4;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [REG_W-1:0] reg_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        reg_t        rd;
        logic        regw;
        logic        flagw;
        logic        cond_passed;
        logic [31:0] value;
        logic [3:0]  flags;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue/writeback/commit and status-query signals between the core (master)
// and the reorder buffer (slave).
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic             Issue;
    logic [3:0]       IssueRd;
    logic             IssueRegW;
    logic             IssueFlagW;
    logic [7:0]       rrs_query;
    logic [1:0]       rrs_result_busy;
    logic [5:0]       rrs_index;
    logic [1:0]       rrs_fwd;
    logic [63:0]      rrs_value;
    logic             fs_flagready;
    logic [2:0]       fs_index;
    logic [3:0]       fs_flags;
    logic [CDB_W-1:0] CDB;
    logic [2:0]       ROBTail;
    logic             Full;
    logic             Empty;
    logic             Commit_Valid;
    logic             Commit_RegW;
    logic [3:0]       Commit_Rd;
    logic [31:0]      Commit_Value;
    logic             Commit_FlagW;
    logic [3:0]       Commit_Flags;

    modport master (
        output Issue, IssueRd, IssueRegW, IssueFlagW, rrs_query, CDB,
        input  rrs_result_busy, rrs_index, rrs_fwd, rrs_value,
               fs_flagready, fs_index, fs_flags, ROBTail, Full, Empty,
               Commit_Valid, Commit_RegW, Commit_Rd, Commit_Value,
               Commit_FlagW, Commit_Flags
    );

    modport slave (
        input  Issue, IssueRd, IssueRegW, IssueFlagW, rrs_query, CDB,
        output rrs_result_busy, rrs_index, rrs_fwd, rrs_value,
               fs_flagready, fs_index, fs_flags, ROBTail, Full, Empty,
               Commit_Valid, Commit_RegW, Commit_Rd, Commit_Value,
               Commit_FlagW, Commit_Flags
    );

endinterface

// File: rtl/reorder_buffer_rrs_table.sv
// Register result status table: per architectural register {busy, tag}, two
// raw lookup ports, issue-over-commit update priority.
module rrs_table
    import reorder_buffer_pkg::*;
(
    input  logic               CLK,
    input  logic               Reset,
    input  logic               alloc_en,
    input  reg_t               alloc_rd,
    input  tag_t               alloc_tag,
    input  logic               commit_en,
    input  reg_t               commit_rd,
    input  tag_t               commit_tag,
    input  logic [2*REG_W-1:0] query,
    output logic [1:0]         busy,
    output logic [2*TAG_W-1:0] tag
);

    logic [NUM_REGS-1:0] busy_q;
    tag_t                tag_q [NUM_REGS];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            busy_q <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            // A retiring producer only releases the register if no younger
            // producer has claimed it, including one claiming it right now.
            if (commit_en && busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag)
                && !(alloc_en && (alloc_rd == commit_rd))) begin
                busy_q[commit_rd] <= 1'b0;
            end
            if (alloc_en) begin
                busy_q[alloc_rd] <= 1'b1;
                tag_q[alloc_rd]  <= alloc_tag;
            end
        end
    end

    always_comb begin
        busy[0]                = busy_q[query[REG_W-1:0]];
        busy[1]                = busy_q[query[2*REG_W-1:REG_W]];
        tag[TAG_W-1:0]         = tag_q[query[REG_W-1:0]];
        tag[2*TAG_W-1:TAG_W]   = tag_q[query[2*REG_W-1:REG_W]];
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with register/flag status lookup and CDB bypass.
// Optional ROB_PERF_EN adds Retired and FullStall counters.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 8
)(
    input  logic            CLK,
    input  logic            Reset,
    reorder_buffer_if.slave rob_if
`ifdef ROB_PERF_EN
    ,
    output logic [31:0]     Retired,
    output logic [31:0]     FullStall
`endif
);

    localparam int unsigned SLOTS = 1 << TAG_W;
    typedef logic [TAG_W:0] cnt_t;
    localparam cnt_t DEPTH_C   = cnt_t'(ROB_DEPTH);
    localparam tag_t PTR_MASK  = tag_t'(ROB_DEPTH - 1);

    // Storage is always sized for the full tag space; slots beyond ROB_DEPTH
    // are never allocated and so never accept a writeback.
    rob_entry_t rob_q [SLOTS];
    tag_t       head_q, tail_q;
    cnt_t       count_q;
    tag_t       fs_tag_q;
    logic       fs_pending_q;
    logic [3:0] arch_flags_q;

    logic        cdb_valid, cdb_cond, cdb_hit, cdb_unused;
    tag_t        cdb_tag;
    logic [31:0] cdb_result;
    logic [3:0]  cdb_nzcv;

    assign cdb_valid  = rob_if.CDB[CDB_VALID];
    assign cdb_tag    = rob_if.CDB[CDB_TAG_HI:CDB_TAG_LO];
    assign cdb_result = rob_if.CDB[CDB_RES_HI:CDB_RES_LO];
    assign cdb_cond   = rob_if.CDB[CDB_COND];
    assign cdb_nzcv   = rob_if.CDB[CDB_NZCV_HI:CDB_NZCV_LO];
    assign cdb_unused = ^rob_if.CDB[CDB_W-1:CDB_NZCV_HI+1];
    assign cdb_hit    = cdb_valid && rob_q[cdb_tag].valid && !rob_q[cdb_tag].done;

    logic       full, empty, do_alloc, do_commit;
    rob_entry_t head_e, alloc_e;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign do_alloc  = rob_if.Issue && !full;
    assign head_e    = rob_q[head_q];
    assign do_commit = head_e.valid && head_e.done;

    assign rob_if.ROBTail = tail_q;
    assign rob_if.Full    = full;
    assign rob_if.Empty   = empty;

    always_comb begin
        alloc_e       = '0;
        alloc_e.valid = 1'b1;
        alloc_e.rd    = rob_if.IssueRd;
        alloc_e.regw  = rob_if.IssueRegW;
        alloc_e.flagw = rob_if.IssueFlagW;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                rob_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (cdb_hit) begin
                rob_q[cdb_tag].done        <= 1'b1;
                rob_q[cdb_tag].value       <= cdb_result;
                rob_q[cdb_tag].cond_passed <= cdb_cond;
                rob_q[cdb_tag].flags       <= cdb_nzcv;
            end
            if (do_commit) begin
                rob_q[head_q].valid <= 1'b0;
                rob_q[head_q].done  <= 1'b0;
                head_q              <= (head_q + tag_t'(1)) & PTR_MASK;
            end
            if (do_alloc) begin
                rob_q[tail_q] <= alloc_e;
                tail_q        <= (tail_q + tag_t'(1)) & PTR_MASK;
            end
            case ({do_alloc, do_commit})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            rob_if.Commit_Valid <= 1'b0;
            rob_if.Commit_RegW  <= 1'b0;
            rob_if.Commit_Rd    <= '0;
            rob_if.Commit_Value <= '0;
            rob_if.Commit_FlagW <= 1'b0;
            rob_if.Commit_Flags <= '0;
        end else begin
            rob_if.Commit_Valid <= do_commit;
            if (do_commit) begin
                rob_if.Commit_RegW  <= head_e.regw && head_e.cond_passed;
                rob_if.Commit_Rd    <= head_e.rd;
                rob_if.Commit_Value <= head_e.value;
                rob_if.Commit_FlagW <= head_e.flagw && head_e.cond_passed;
                rob_if.Commit_Flags <= head_e.flags;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            fs_tag_q     <= '0;
            fs_pending_q <= 1'b0;
            arch_flags_q <= '0;
        end else begin
            if (do_commit && head_e.flagw && head_e.cond_passed) begin
                arch_flags_q <= head_e.flags;
            end
            if (do_alloc && rob_if.IssueFlagW) begin
                fs_tag_q     <= tail_q;
                fs_pending_q <= 1'b1;
            end else if (do_commit && head_e.flagw && (fs_tag_q == head_q)) begin
                fs_pending_q <= 1'b0;
            end
        end
    end

    logic [1:0]         rrs_busy_raw;
    logic [2*TAG_W-1:0] rrs_tag_raw;
    tag_t               src_tag [2];

    rrs_table u_rrs (
        .CLK        (CLK),
        .Reset      (Reset),
        .alloc_en   (do_alloc && rob_if.IssueRegW),
        .alloc_rd   (rob_if.IssueRd),
        .alloc_tag  (tail_q),
        .commit_en  (do_commit && head_e.regw),
        .commit_rd  (head_e.rd),
        .commit_tag (head_q),
        .query      (rob_if.rrs_query),
        .busy       (rrs_busy_raw),
        .tag        (rrs_tag_raw)
    );

    assign src_tag[0] = rrs_tag_raw[TAG_W-1:0];
    assign src_tag[1] = rrs_tag_raw[2*TAG_W-1:TAG_W];

    always_comb begin
        rob_if.rrs_result_busy = '0;
        rob_if.rrs_fwd         = '0;
        rob_if.rrs_value       = '0;
        rob_if.rrs_index       = rrs_tag_raw;
        for (int unsigned k = 0; k < 2; k++) begin
            if (rrs_busy_raw[k]) begin
                if (rob_q[src_tag[k]].done) begin
                    rob_if.rrs_fwd[k]           = 1'b1;
                    rob_if.rrs_value[k*32 +: 32] = rob_q[src_tag[k]].value;
                end else if (cdb_valid && (cdb_tag == src_tag[k])) begin
                    rob_if.rrs_fwd[k]           = 1'b1;
                    rob_if.rrs_value[k*32 +: 32] = cdb_result;
                end else begin
                    rob_if.rrs_result_busy[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rob_if.fs_index     = fs_tag_q;
        rob_if.fs_flagready = 1'b1;
        rob_if.fs_flags     = arch_flags_q;
        if (fs_pending_q) begin
            if (rob_q[fs_tag_q].done) begin
                rob_if.fs_flags = rob_q[fs_tag_q].flags;
            end else if (cdb_valid && (cdb_tag == fs_tag_q)) begin
                rob_if.fs_flags = cdb_nzcv;
            end else begin
                rob_if.fs_flagready = 1'b0;
            end
        end
    end

`ifdef ROB_PERF_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Retired   <= '0;
            FullStall <= '0;
        end else begin
            if (do_commit) begin
                Retired <= Retired + 32'd1;
            end
            if (rob_if.Issue && full) begin
                FullStall <= FullStall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed steps plus random traffic checked against
// a program-order queue model of in-flight instructions.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic CLK;
    logic Reset;
    reorder_buffer_if rif();
`ifdef ROB_PERF_EN
    logic [31:0] Retired;
    logic [31:0] FullStall;
`endif

    reorder_buffer #(.ROB_DEPTH(DEPTH)) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .rob_if (rif)
`ifdef ROB_PERF_EN
        ,
        .Retired   (Retired),
        .FullStall (FullStall)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0]  tag;
        logic [3:0]  rd;
        bit          regw;
        bit          flagw;
        bit          done;
        bit          cond;
        logic [31:0] val;
        logic [3:0]  nz;
    } m_ent_t;

    m_ent_t      q[$];
    int unsigned next_tag;
    logic [3:0]  m_flags;
    logic [2:0]  m_fs_idx;
    bit          e_cv, e_regw, e_flagw;
    logic [3:0]  e_rd, e_nz;
    logic [31:0] e_val;
    int unsigned m_retired, m_stall;
    int          n_checks = 0;
    int          n_fail   = 0;

    bit          cur_iss, cur_rw, cur_fw, cur_cv, cur_cc;
    logic [3:0]  cur_rd, cur_nz;
    logic [2:0]  cur_ct;
    logic [31:0] cur_val;
    logic [7:0]  cur_qry;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [147:0] make_cdb(input bit v, input logic [2:0] t,
                                              input logic [31:0] val, input bit c,
                                              input logic [3:0] nz);
        logic [147:0] b;
        b = '0;
        for (int i = 41; i < 148; i++) b[i] = 1'($urandom);
        b[3]     = v;
        b[2:0]   = t;
        b[35:4]  = val;
        b[36]    = c;
        b[40:37] = nz;
        return b;
    endfunction

    task automatic drive(input bit iss, input logic [3:0] rd, input bit rw, input bit fw,
                         input bit cv, input logic [2:0] ct, input logic [31:0] val,
                         input bit cc, input logic [3:0] nz, input logic [7:0] qry);
        cur_iss = iss; cur_rd = rd; cur_rw = rw; cur_fw = fw;
        cur_cv = cv; cur_ct = ct; cur_val = val; cur_cc = cc; cur_nz = nz; cur_qry = qry;
        rif.Issue      = iss;
        rif.IssueRd    = rd;
        rif.IssueRegW  = rw;
        rif.IssueFlagW = fw;
        rif.CDB        = make_cdb(cv, ct, val, cc, nz);
        rif.rrs_query  = qry;
    endtask

    task automatic check_comb();
        int         j;
        logic [3:0] r;
        chk("rob_tail", rif.ROBTail, 3'(next_tag));
        chk("full", rif.Full, q.size() == DEPTH);
        chk("empty", rif.Empty, q.size() == 0);
        for (int k = 0; k < 2; k++) begin
            r = cur_qry[k*4 +: 4];
            j = -1;
            for (int i = 0; i < q.size(); i++) if (q[i].regw && q[i].rd == r) j = i;
            if (j < 0) begin
                chk("rrs_busy_idle", rif.rrs_result_busy[k], 1'b0);
                chk("rrs_fwd_idle", rif.rrs_fwd[k], 1'b0);
            end else if (q[j].done) begin
                chk("rrs_busy_done", rif.rrs_result_busy[k], 1'b0);
                chk("rrs_fwd_done", rif.rrs_fwd[k], 1'b1);
                chk("rrs_value_done", rif.rrs_value[k*32 +: 32], q[j].val);
            end else if (cur_cv && cur_ct == q[j].tag) begin
                chk("rrs_busy_byp", rif.rrs_result_busy[k], 1'b0);
                chk("rrs_fwd_byp", rif.rrs_fwd[k], 1'b1);
                chk("rrs_value_byp", rif.rrs_value[k*32 +: 32], cur_val);
            end else begin
                chk("rrs_busy_wait", rif.rrs_result_busy[k], 1'b1);
                chk("rrs_fwd_wait", rif.rrs_fwd[k], 1'b0);
                chk("rrs_index", rif.rrs_index[k*3 +: 3], q[j].tag);
            end
        end
        j = -1;
        for (int i = 0; i < q.size(); i++) if (q[i].flagw) j = i;
        chk("fs_index", rif.fs_index, m_fs_idx);
        if (j < 0) begin
            chk("fs_ready_idle", rif.fs_flagready, 1'b1);
            chk("fs_flags_idle", rif.fs_flags, m_flags);
        end else if (q[j].done) begin
            chk("fs_ready_done", rif.fs_flagready, 1'b1);
            chk("fs_flags_done", rif.fs_flags, q[j].nz);
        end else if (cur_cv && cur_ct == q[j].tag) begin
            chk("fs_ready_byp", rif.fs_flagready, 1'b1);
            chk("fs_flags_byp", rif.fs_flags, cur_nz);
        end else begin
            chk("fs_ready_wait", rif.fs_flagready, 1'b0);
            chk("fs_flags_wait", rif.fs_flags, m_flags);
        end
    endtask

    task automatic check_seq();
        chk("commit_valid", rif.Commit_Valid, e_cv);
        chk("commit_regw", rif.Commit_RegW, e_regw);
        chk("commit_rd", rif.Commit_Rd, e_rd);
        chk("commit_value", rif.Commit_Value, e_val);
        chk("commit_flagw", rif.Commit_FlagW, e_flagw);
        chk("commit_flags", rif.Commit_Flags, e_nz);
        chk("seq_full", rif.Full, q.size() == DEPTH);
        chk("seq_empty", rif.Empty, q.size() == 0);
        chk("seq_tail", rif.ROBTail, 3'(next_tag));
`ifdef ROB_PERF_EN
        chk("retired", Retired, m_retired);
        chk("full_stall", FullStall, m_stall);
`endif
    endtask

    // Reference behaviour at a clock edge, in program-order terms.
    task automatic model_edge();
        bit     commit;
        m_ent_t e;
        commit = (q.size() > 0) && q[0].done;
        if (cur_cv) begin
            foreach (q[i]) begin
                if (q[i].tag == cur_ct && !q[i].done) begin
                    q[i].done = 1'b1; q[i].val = cur_val; q[i].cond = cur_cc; q[i].nz = cur_nz;
                end
            end
        end
        if (cur_iss) begin
            if (q.size() < DEPTH) begin
                e.tag = 3'(next_tag); e.rd = cur_rd; e.regw = cur_rw; e.flagw = cur_fw;
                e.done = 1'b0; e.cond = 1'b0; e.val = '0; e.nz = '0;
                q.push_back(e);
                if (cur_fw) m_fs_idx = 3'(next_tag);
                next_tag = (next_tag + 1) % DEPTH;
            end else begin
                m_stall++;
            end
        end
        e_cv = commit;
        if (commit) begin
            e = q.pop_front();
            e_regw  = e.regw && e.cond;
            e_rd    = e.rd;
            e_val   = e.val;
            e_flagw = e.flagw && e.cond;
            e_nz    = e.nz;
            if (e.flagw && e.cond) m_flags = e.nz;
            m_retired++;
        end
    endtask

    task automatic step(input bit iss, input logic [3:0] rd, input bit rw, input bit fw,
                        input bit cv, input logic [2:0] ct, input logic [31:0] val,
                        input bit cc, input logic [3:0] nz, input logic [7:0] qry);
        @(negedge CLK);
        drive(iss, rd, rw, fw, cv, ct, val, cc, nz, qry);
        #1 check_comb();
        @(posedge CLK);
        model_edge();
        #1 check_seq();
    endtask

    task automatic idle(input logic [7:0] qry);
        step(0, 4'd0, 0, 0, 0, 3'd0, 32'd0, 0, 4'd0, qry);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b1;
        drive(1, 4'd1, 1, 1, 1, 3'd0, 32'hdead_beef, 1, 4'hf, 8'h10);
        @(posedge CLK);
        q.delete();
        next_tag = 0; m_flags = '0; m_fs_idx = '0;
        e_cv = 0; e_regw = 0; e_flagw = 0; e_rd = '0; e_nz = '0; e_val = '0;
        m_retired = 0; m_stall = 0;
        #1 check_seq();
        @(negedge CLK);
        Reset = 1'b0;
        drive(0, 4'd0, 0, 0, 0, 3'd0, 32'd0, 0, 4'd0, 8'h00);
        #1 check_comb();
        chk("rst_busy", rif.rrs_result_busy, 2'b00);
        chk("rst_flagready", rif.fs_flagready, 1'b1);
    endtask

    function automatic logic [3:0] pick_src();
        if (q.size() > 0 && $urandom_range(0, 1) == 1)
            return q[$urandom_range(0, q.size() - 1)].rd;
        return 4'($urandom);
    endfunction

    initial begin
        Reset = 1'b1;
        drive(0, 4'd0, 0, 0, 0, 3'd0, 32'd0, 0, 4'd0, 8'h00);
        do_reset();

        // Allocation and lookup of a waiting producer.
        step(1, 4'd3, 1, 0, 0, 3'd0, 32'd0, 0, 4'd0, 8'h00);
        drive(0, 4'd0, 0, 0, 0, 3'd0, 32'd0, 0, 4'd0, {4'd0, 4'd3});
        #1;
        chk("tp1_busy", rif.rrs_result_busy, 2'b01);
        chk("tp1_index", rif.rrs_index[2:0], 3'd0);

        // Writeback then commit one cycle later.
        step(0, 4'd0, 0, 0, 1, 3'd0, 32'h0000_1234, 1, 4'h0, 8'h03);
        chk("tp2_no_commit_yet", rif.Commit_Valid, 1'b0);
        idle(8'h03);
        chk("tp2_commit", rif.Commit_Valid, 1'b1);
        chk("tp2_rd", rif.Commit_Rd, 4'd3);
        chk("tp2_value", rif.Commit_Value, 32'h0000_1234);
        chk("tp2_empty", rif.Empty, 1'b1);
        idle(8'h03);
        chk("tp2_one_cycle", rif.Commit_Valid, 1'b0);

        // Fill to capacity, then a refused issue.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 4'(i), 1, i[0], 0, 3'd0, 32'd0, 0, 4'd0, 8'h21);
        chk("tp3_full", rif.Full, 1'b1);
        step(1, 4'd9, 1, 1, 0, 3'd0, 32'd0, 0, 4'd0, 8'h09);
        chk("tp3_tail", rif.ROBTail, 3'd0);
        chk("tp3_still_full", rif.Full, 1'b1);
`ifdef ROB_PERF_EN
        chk("tp3_retired", Retired, 32'd0);
        chk("tp3_stall", FullStall, 32'd1);
`endif

        // Reset while the head is eligible: nothing retires.
        step(0, 4'd0, 0, 0, 1, 3'd0, 32'h5a5a_0000, 1, 4'h3, 8'h00);
        do_reset();
        chk("tp_midreset_empty", rif.Empty, 1'b1);

        // Re-allocated register survives the older producer's commit.
        step(1, 4'd5, 1, 1, 0, 3'd0, 32'd0, 0, 4'd0, 8'h05);
        step(1, 4'd5, 1, 0, 0, 3'd0, 32'd0, 0, 4'd0, 8'h05);
        step(0, 4'd0, 0, 0, 1, 3'd0, 32'h0000_0055, 1, 4'h8, 8'h05);
        idle(8'h05);
        chk("tp4_commit", rif.Commit_Valid, 1'b1);
        drive(0, 4'd0, 0, 0, 0, 3'd0, 32'd0, 0, 4'd0, {4'd0, 4'd5});
        #1;
        chk("tp4_busy", rif.rrs_result_busy, 2'b01);
        chk("tp4_index", rif.rrs_index[2:0], 3'd1);

        // Same-cycle CDB bypass.
        step(1, 4'd7, 1, 1, 0, 3'd0, 32'd0, 0, 4'd0, 8'h75);
        drive(0, 4'd0, 0, 0, 1, 3'd2, 32'hcafe_f00d, 1, 4'h6, {4'd0, 4'd7});
        #1;
        chk("tp5_fwd", rif.rrs_fwd, 2'b01);
        chk("tp5_busy", rif.rrs_result_busy, 2'b00);
        chk("tp5_value", rif.rrs_value[31:0], 32'hcafe_f00d);
        chk("tp5_flagready", rif.fs_flagready, 1'b1);
        chk("tp5_flags", rif.fs_flags, 4'h6);
        step(0, 4'd0, 0, 0, 1, 3'd2, 32'hcafe_f00d, 1, 4'h6, {4'd0, 4'd7});

        // Younger done first: head blocks, then two back-to-back commits.
        idle(8'h57);
        chk("tp6_blocked", rif.Commit_Valid, 1'b0);
        idle(8'h57);
        chk("tp6_blocked2", rif.Commit_Valid, 1'b0);
        step(0, 4'd0, 0, 0, 1, 3'd1, 32'h0000_0abc, 1, 4'h1, 8'h57);
        idle(8'h57);
        chk("tp6_c1", rif.Commit_Valid, 1'b1);
        chk("tp6_c1_rd", rif.Commit_Rd, 4'd5);
        idle(8'h57);
        chk("tp6_c2", rif.Commit_Valid, 1'b1);
        chk("tp6_c2_value", rif.Commit_Value, 32'hcafe_f00d);
        idle(8'h57);
        chk("tp6_done", rif.Commit_Valid, 1'b0);

        // Random traffic against the queue model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit          iss, rw, fw, cv, cc;
            logic [3:0]  rd, nz, s0, s1;
            logic [2:0]  ct;
            logic [31:0] val;
            int          idx[$];
            iss = ($urandom_range(0, 99) < 55);
            rd  = 4'($urandom_range(0, 9));
            rw  = ($urandom_range(0, 3) != 0);
            fw  = ($urandom_range(0, 2) == 0);
            cv  = ($urandom_range(0, 99) < 50);
            cc  = ($urandom_range(0, 3) != 0);
            val = $urandom;
            nz  = 4'($urandom);
            idx.delete();
            foreach (q[i]) if (!q[i].done) idx.push_back(i);
            if (idx.size() > 0 && $urandom_range(0, 3) != 0)
                ct = q[idx[$urandom_range(0, idx.size() - 1)]].tag;
            else
                ct = 3'($urandom);
            s0 = pick_src();
            s1 = pick_src();
            step(iss, rd, rw, fw, cv, ct, val, cc, nz, {s1, s0});
            if (n == 300) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
